// File: rtl/sample_capture.sv
// Triggered logic-analyser capture buffer: circular pre-trigger history, a
// post-trigger sample budget and registered readout ordered oldest-first.
module sample_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [AW:0]           post_count,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [AW:0]           sample_count,
    output logic [AW-1:0]         trig_pos
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_TRIGGERED,
        S_DONE
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] MAX_POST   = (AW+1)'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW:0]           r_sample_count;
    logic [AW-1:0]         r_trig_pos;
    logic [AW:0]           r_post;
    logic [AW:0]           r_remaining;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_value;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic                  w_active;
    logic                  w_write;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_arm_go;
    logic                  w_full;
    logic                  w_rd_go;
    logic [AW:0]           w_post_clamped;
    logic [AW-1:0]         w_oldest;
    logic [AW-1:0]         w_rd_addr;
    logic [DATA_WIDTH-1:0] w_bit_match;

    // A masked-out bit always matches; a masked-in bit must equal its level.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_match
            assign w_bit_match[gi] = ~r_mask[gi] | (din[gi] == r_value[gi]);
        end
    endgenerate

    assign w_active       = (r_state == S_ARMED) || (r_state == S_TRIGGERED);
    assign w_write        = ce && w_active && !abort && !rst;
    assign w_hit          = w_write && (r_state == S_ARMED) && (&w_bit_match);
    assign w_last         = w_write && (r_state == S_TRIGGERED) && (r_remaining == (AW+1)'(1));
    assign w_arm_go       = arm && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_full         = (r_sample_count == FULL_COUNT);
    assign w_rd_go        = rd_en && (r_state == S_DONE);
    assign w_post_clamped = (post_count > MAX_POST) ? MAX_POST : post_count;
    assign w_oldest       = r_wr_ptr - r_sample_count[AW-1:0];
    assign w_rd_addr      = w_oldest + rd_idx;

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (arm) w_state_next = S_ARMED;
                S_ARMED:        if (w_hit) w_state_next = (r_post == '0) ? S_DONE : S_TRIGGERED;
                S_TRIGGERED:    if (w_last) w_state_next = S_DONE;
                default:        w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_sample_count <= '0;
            r_trig_pos     <= '0;
            r_post         <= '0;
            r_remaining    <= '0;
            r_mask         <= '0;
            r_value        <= '0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_arm_go) begin
                r_wr_ptr       <= '0;
                r_sample_count <= '0;
                r_post         <= w_post_clamped;
                r_mask         <= trig_mask;
                r_value        <= trig_value;
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (!w_full) r_sample_count <= r_sample_count + (AW+1)'(1);
            end
            // Trigger index tracks the trigger sample as the oldest entries are overwritten.
            if (w_hit) begin
                r_remaining <= r_post;
                r_trig_pos  <= w_full ? AW'(DEPTH - 1) : r_sample_count[AW-1:0];
            end else if (w_write && (r_state == S_TRIGGERED)) begin
                r_remaining <= r_remaining - (AW+1)'(1);
                if (w_full) r_trig_pos <= r_trig_pos - AW'(1);
            end
            r_rd_valid <= w_rd_go;
            if (w_rd_go) r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr] <= din;
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign busy         = w_active;
    assign triggered    = (r_state == S_TRIGGERED) || (r_state == S_DONE);
    assign done         = (r_state == S_DONE);
    assign sample_count = r_sample_count;
    assign trig_pos     = r_trig_pos;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture (DATA_WIDTH=8, DEPTH=16): a capture
// scenario table plus hand-written sequences for read, abort and reset corners.
module tb_sample_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic [7:0] din = '0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] trig_mask = '0;
    logic [7:0] trig_value = '0;
    logic [4:0] post_count = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_idx = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       triggered;
    logic       done;
    logic [4:0] sample_count;
    logic [3:0] trig_pos;

    int checks = 0;
    int errors = 0;

    sample_capture #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value), .post_count(post_count),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .triggered(triggered), .done(done),
        .sample_count(sample_count), .trig_pos(trig_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] value;
        logic [4:0] post;
        logic [7:0] base;
        logic [7:0] mult;
        int         n_ce;
        int         inj_k;
        logic [7:0] inj_val;
        int         done_at;
        logic [4:0] exp_count;
        logic [3:0] exp_tp;
        logic [3:0] idx_a;
        logic [7:0] exp_a;
        logic [3:0] idx_b;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_arm(input logic [7:0] m, input logic [7:0] v, input logic [4:0] p);
        trig_mask = m; trig_value = v; post_count = p; arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic sample(input logic [7:0] d);
        ce = 1'b1; din = d;
        step();
        ce = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] idx, input logic [7:0] exp);
        rd_en = 1'b1; rd_idx = idx;
        step();
        rd_en = 1'b0;
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk(name, 32'(rd_data), 32'(exp));
        step();
        chk({name, "_valid_drop"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 5'd3,  8'hA0, 8'd1, 4,  -1, 8'h00, 4,  5'd4,  4'd0,  4'd0, 8'hA0, 4'd3,  8'hA3};
        vecs[1] = '{8'hFF, 8'h55, 5'd2,  8'h00, 8'd1, 20, 10, 8'h55, 13, 5'd13, 4'd10, 4'd10, 8'h55, 4'd12, 8'h0C};
        vecs[2] = '{8'h01, 8'h01, 5'd4,  8'h00, 8'd2, 34, 29, 8'h01, 34, 5'd16, 4'd11, 4'd0, 8'h24, 4'd11, 8'h01};
        vecs[3] = '{8'h00, 8'h00, 5'd20, 8'h30, 8'd1, 16, -1, 8'h00, 16, 5'd16, 4'd0,  4'd0, 8'h30, 4'd15, 8'h3F};
        vecs[4] = '{8'h00, 8'h00, 5'd0,  8'h10, 8'd1, 3,  -1, 8'h00, 1,  5'd1,  4'd0,  4'd0, 8'h10, 4'd0,  8'h10};

        // Reset state
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        chk("rst_trig_pos", 32'(trig_pos), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        step();

        // arm and ce together in IDLE: arm only, the sample is not taken
        trig_mask = 8'h00; post_count = 5'd3; arm = 1'b1; ce = 1'b1; din = 8'h77;
        step();
        arm = 1'b0; ce = 1'b0;
        chk("armce_busy", 32'(busy), 32'd1);
        chk("armce_triggered", 32'(triggered), 32'd0);
        chk("armce_count", 32'(sample_count), 32'd0);
        $display("seq arm+ce in IDLE: busy=%0d count=%0d", busy, sample_count);
        abort = 1'b1;
        step();
        abort = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_arm(vecs[i].mask, vecs[i].value, vecs[i].post);
            chk($sformatf("v%0d_armed", i), 32'(busy), 32'd1);
            for (int k = 0; k < vecs[i].n_ce; k++) begin
                logic [7:0] d;
                d = (k == vecs[i].inj_k) ? vecs[i].inj_val
                                         : 8'(int'(vecs[i].base) + int'(vecs[i].mult) * k);
                sample(d);
                chk($sformatf("v%0d_done_ce%0d", i, k + 1), 32'(done),
                    32'((k + 1) >= vecs[i].done_at));
            end
            chk($sformatf("v%0d_count", i), 32'(sample_count), 32'(vecs[i].exp_count));
            chk($sformatf("v%0d_trig_pos", i), 32'(trig_pos), 32'(vecs[i].exp_tp));
            chk($sformatf("v%0d_triggered", i), 32'(triggered), 32'd1);
            rd_check($sformatf("v%0d_rd_a", i), vecs[i].idx_a, vecs[i].exp_a);
            rd_check($sformatf("v%0d_rd_b", i), vecs[i].idx_b, vecs[i].exp_b);
            $display("vec %0d: count=%0d trig_pos=%0d done=%0d", i, sample_count, trig_pos, done);
        end

        // Readout gated to DONE; back-to-back reads one cycle apart
        do_arm(8'hFF, 8'hEE, 5'd1);
        rd_en = 1'b1; rd_idx = 4'd0;
        step();
        rd_en = 1'b0;
        chk("armed_rd_valid", 32'(rd_valid), 32'd0);
        sample(8'h11);
        sample(8'hEE);
        chk("seq_trig_state", 32'(triggered & busy), 32'd1);
        sample(8'h22);
        chk("seq_done", 32'(done), 32'd1);
        chk("seq_count", 32'(sample_count), 32'd3);
        chk("seq_trig_pos", 32'(trig_pos), 32'd1);
        rd_en = 1'b1; rd_idx = 4'd0;
        step();
        chk("b2b_valid0", 32'(rd_valid), 32'd1);
        chk("b2b_data0", 32'(rd_data), 32'h11);
        rd_idx = 4'd2;
        step();
        rd_en = 1'b0;
        chk("b2b_valid1", 32'(rd_valid), 32'd1);
        chk("b2b_data1", 32'(rd_data), 32'h22);
        step();
        chk("b2b_valid_drop", 32'(rd_valid), 32'd0);
        $display("seq readout: back-to-back reads complete");

        // Abort with arm during TRIGGERED, then reset while ARMED
        do_arm(8'h00, 8'h00, 5'd5);
        sample(8'h01);
        chk("ab_triggered", 32'(triggered), 32'd1);
        chk("ab_busy_pre", 32'(busy), 32'd1);
        abort = 1'b1; arm = 1'b1;
        step();
        abort = 1'b0; arm = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_triggered_clr", 32'(triggered), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_count_hold", 32'(sample_count), 32'd1);
        $display("seq abort+arm: busy=%0d triggered=%0d", busy, triggered);
        do_arm(8'hFF, 8'h00, 5'd2);
        sample(8'h03);
        chk("rearm_busy", 32'(busy), 32'd1);
        chk("rearm_count", 32'(sample_count), 32'd1);
        rst = 1'b1; rd_en = 1'b1;
        step();
        rst = 1'b0; rd_en = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_triggered", 32'(triggered), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_count", 32'(sample_count), 32'd0);
        chk("mrst_trig_pos", 32'(trig_pos), 32'd0);
        chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mrst_rd_data", 32'(rd_data), 32'd0);
        $display("seq reset mid-ARMED: busy=%0d count=%0d", busy, sample_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of sampled probe bus.
REQ-002 SHALL have parameter DEPTH, default 256: sample memory depth, a power of two, at least 4; AW = log2(DEPTH).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port ce, input, 1: sample strobe from the prescaler, one clk cycle wide.
REQ-006 SHALL have port din, input, DATA_WIDTH: probe inputs.
REQ-007 SHALL have port arm, input, 1: start capture pulse.
REQ-008 SHALL have port abort, input, 1: cancel capture pulse.
REQ-009 SHALL have ports trig_mask and trig_value, input, DATA_WIDTH each: trigger bits to compare, and their required levels.
REQ-010 SHALL have port post_count, input, AW+1: number of samples to store after the trigger sample.
REQ-011 SHALL have ports rd_en, input, 1, and rd_idx, input, AW: readout request and sample index (0 = oldest).
REQ-012 SHALL have ports rd_data, output, DATA_WIDTH, and rd_valid, output, 1: readout data and its qualifier.
REQ-013 SHALL have ports busy, triggered, done, output, 1 each: status flags.
REQ-014 SHALL have port sample_count, output, AW+1: number of valid stored samples.
REQ-015 SHALL have port trig_pos, output, AW: readout index of the trigger sample.

Function
REQ-016 SHALL implement states IDLE, ARMED, TRIGGERED, DONE; busy=1 in ARMED/TRIGGERED, triggered=1 in TRIGGERED/DONE, done=1 in DONE.
REQ-017 SHALL, on arm in IDLE or DONE: go to ARMED, clear wr_ptr and sample_count, latch post_count as min(post_count, DEPTH-1), latch trig_mask/trig_value.
REQ-018 SHALL ignore arm in ARMED or TRIGGERED.
REQ-019 SHALL, on abort in any state, go to IDLE next cycle; abort wins over a simultaneous arm; memory contents and sample_count hold.
REQ-020 SHALL, on each ce cycle in ARMED or TRIGGERED: write din to mem[wr_ptr], increment wr_ptr modulo DEPTH, increment sample_count saturating at DEPTH.
REQ-021 SHALL ignore ce and din in IDLE and DONE; no memory write occurs.
REQ-022 SHALL detect a trigger when, on a ce cycle in ARMED, ((din XOR trig_value) AND trig_mask) == 0; an all-zero mask triggers on the first ce sample.
REQ-023 SHALL store the trigger sample itself; if the latched post_count is 0, go to DONE the next cycle, else go to TRIGGERED with remaining = post_count.
REQ-024 SHALL, in TRIGGERED, decrement remaining on each ce and enter DONE on the cycle the last post-trigger sample is written.
REQ-025 SHALL record trig_pos at the trigger as (sample_count after the trigger write) - 1, minus any oldest samples later overwritten; it is valid only in DONE.
REQ-026 SHALL compute oldest = (wr_ptr - sample_count) mod DEPTH.
REQ-027 SHALL, on rd_en in DONE, present rd_data = mem[(oldest + rd_idx) mod DEPTH] with rd_valid=1 on the next cycle (1-cycle latency), with back-to-back reads allowed.
REQ-028 SHALL ignore rd_en outside DONE, keeping rd_valid=0; rd_idx >= sample_count returns unspecified data with rd_valid=1.
REQ-029 SHALL treat ce and arm in the same cycle in IDLE/DONE as arm only; that ce is not sampled.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, set state=IDLE, wr_ptr=0, sample_count=0, trig_pos=0, rd_valid=0, rd_data=0, busy=triggered=done=0, regardless of state; memory is not cleared.
REQ-031 SHALL give rst priority over arm, abort, ce and rd_en.

Verification (DATA_WIDTH=8, DEPTH=16)
REQ-032 SHALL cover: mask=0x00, post_count=3, arm, ce on din=0xA0..0xA3 -> done after 4th ce, sample_count=4, trig_pos=0, reads idx0..3 = 0xA0..0xA3.
REQ-033 SHALL cover: mask=0xFF, value=0x55, post_count=2, 20 ce samples 0x00..0x13 with 0x55 injected as 11th -> sample_count=13, trig_pos=10, idx10=0x55.
REQ-034 SHALL cover: pre-trigger wrap with mask=0x01, value=0x01, post_count=4, even values until ce #30, then 0x01 -> sample_count=16, trig_pos=11, idx0 = sample #19.
REQ-035 SHALL cover: post_count=20 -> clamped to 15; trigger on first ce -> DONE after 16 ce, trig_pos=0.
REQ-036 SHALL cover: abort with arm in the same cycle during TRIGGERED -> IDLE, busy=0; then rst mid-ARMED -> all outputs 0 on the next cycle.
REQ-037 SHALL cover: rd_en while ARMED -> rd_valid stays 0; rd_en in DONE -> rd_valid exactly one cycle later per request.
